series_eval: RTL and testbench
==============================

SERIES_EVAL -- requirements
Module: series_eval

Interface
REQ-001 Parameter WIDTH, default 16, signed two's-complement data width.
REQ-002 Parameter FRAC, default 12, fractional bits of the fixed-point format; the value 1.0 is 2^FRAC.
REQ-003 Parameter NTERMS, default 8, maximum number of series terms; CW = clog2(NTERMS+1).
REQ-004 Port clk, input, 1, clock; all state changes on the rising edge.
REQ-005 Port rst, input, 1, reset; asynchronous, active-high.
REQ-006 Port start, input, 1, request; sampled only while ready=1.
REQ-007 Port abort, input, 1, cancels the operation in progress; ignored in IDLE.
REQ-008 Port x, input, WIDTH, series argument; latched when start is accepted.
REQ-009 Port nterms, input, CW, runtime term count (0..NTERMS); latched when start is accepted.
REQ-010 Port coef_addr, output, CW, term index i presented to an external combinational coefficient ROM.
REQ-011 Port coef_data, input, WIDTH, coefficient c_i; valid in the same cycle as coef_addr.
REQ-012 Port ready, output, 1, high in IDLE only.
REQ-013 Port busy, output, 1, high in every non-IDLE state.
REQ-014 Port done, output, 1, one-cycle completion pulse.
REQ-015 Port result, output, WIDTH, registered sum; holds its value until the next completion.
REQ-016 Port ovf, output, 1, sticky saturation flag for the operation that produced result.

Function
REQ-017 The block SHALL compute r = sum over i=0..n-1 of c_i*x^i, with n the latched nterms, using one shared multiplier.
REQ-018 States: IDLE, INIT, MULC, ACC, MULX, DONE.
REQ-019 IDLE->INIT when start=1; x and nterms are latched on that edge.
REQ-020 INIT: term t=1.0, accumulator a=0, index i=0, internal ovf cleared; next state MULC if n>0, else DONE.
REQ-021 MULC: p = t*c_i, using coef_data at coef_addr=i; next state ACC.
REQ-022 ACC: a = a+p and i=i+1; next state DONE if i+1==n, else MULX.
REQ-023 MULX: t = t*x; next state MULC.
REQ-024 DONE: result<=a and ovf<=internal ovf, loaded on entry to DONE; done=1 for that one cycle; next state IDLE.
REQ-025 Latency: done SHALL be high in cycle 3n+1 after the start-sampling edge, where INIT is cycle 1; for n=0, done is high in cycle 2.
REQ-026 Multiply: full 2*WIDTH signed product, arithmetic shift right by FRAC (truncation), then saturation to WIDTH.
REQ-027 Add: saturating WIDTH-bit signed addition.
REQ-028 Any saturation event SHALL set the internal ovf flag, which stays set until the next INIT.
REQ-029 If start is still high in the IDLE cycle after DONE, a new operation SHALL begin; start never needs to be deasserted.
REQ-030 abort=1 in any state other than IDLE SHALL force the next state to IDLE; done stays low, and result and ovf keep their previous values.
REQ-031 abort has priority over every other transition.
REQ-032 An nterms value greater than NTERMS SHALL be clamped to NTERMS when latched.

Reset
REQ-033 rst SHALL set state to IDLE and clear result, ovf, done, t, a, i and the latched x and nterms, so ready=1 and busy=0.
REQ-034 rst asserted mid-operation SHALL abandon the operation with no done pulse.

Structure
REQ-035 Shared package series_pkg: state enumeration, default parameter values, fixed-point ONE constant, and the saturation helper function.
REQ-036 One sub-module, sat_mul: combinational signed fixed-point multiply with truncation, saturation and an overflow flag output.

Verification (WIDTH=16, FRAC=12)
REQ-037 Stimulus x=2048 (0.5), all c_i=4096, nterms=4. Response: done in cycle 13, result=7680, ovf=0.
REQ-038 Stimulus nterms=1, c_0=-1234. Response: done in cycle 4, result=-1234; nterms=0 gives done in cycle 2 and result=0.
REQ-039 Stimulus x=16384 (4.0), all c_i=16384, nterms=3. Response: result=32767, ovf=1; a following run with x=0 and nterms=2 returns c_0 with ovf=0.
REQ-040 Stimulus abort in cycle 5 of an nterms=4 run. Response: IDLE next cycle, no done, and result still equal to the prior value.
REQ-041 Stimulus rst asserted in MULX. Response: immediate IDLE and all outputs zero; start held high continuously yields back-to-back operations with a single IDLE cycle between each done.

Source files
------------

// File: rtl/series_pkg.sv
// series_pkg -- shared definitions for the series evaluator.
//   * default parameter values (data width, fraction bits, term count)
//   * fixed-point ONE for the default format
//   * FSM state encodings (plain localparams so older code can include them)
//   * sat_check(): classifies a wide signed value against a WIDTH-bit range
package series_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int FRAC_DEF   = 12;
  localparam int NTERMS_DEF = 8;

  // 1.0 in the default Q(WIDTH-FRAC).FRAC format.
  localparam longint ONE_DEF = 64'sd1 <<< FRAC_DEF;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_MULC = 3'd2;
  localparam logic [2:0] S_ACC  = 3'd3;
  localparam logic [2:0] S_MULX = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_HI   = 2'd1,
    SAT_LO   = 2'd2
  } sat_e;

  // Reports whether v lies above, below or inside the signed range of a
  // w-bit two's-complement number. The caller substitutes the rail value.
  function automatic sat_e sat_check(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return SAT_HI;
    if (v < lo) return SAT_LO;
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/series_eval_sat_mul.sv
// sat_mul -- combinational signed fixed-point multiplier.
//   a, b : WIDTH-bit signed operands, FRAC fractional bits
//   y    : (a*b) >>> FRAC, truncated toward -inf, saturated to WIDTH bits
//   ovf  : high when y was clamped to a rail
module sat_mul
  import series_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y,
  output logic                    ovf
);

  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] prod;
  logic signed [63:0]        wide;
  logic signed [63:0]        shifted;
  sat_e                      sat;

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (here unconditionally), otherwise synthesis infers a latch.
  always_comb begin
    prod    = a * b;
    wide    = 64'(prod);          // signed cast sign-extends
    shifted = wide >>> FRAC;
    sat     = sat_check(shifted, WIDTH);
    ovf     = (sat != SAT_NONE);
    case (sat)
      SAT_HI:  y = SMAX;
      SAT_LO:  y = SMIN;
      default: y = shifted[WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/series_eval.sv
// series_eval -- sequential evaluator of r = sum_{i<n} c_i * x^i in signed
// fixed point, using a single shared saturating multiplier.
//   clk, rst          : clock, asynchronous active-high reset
//   start, x, nterms  : request; x and nterms latched when accepted in IDLE
//   abort             : drop the current operation (no done, outputs kept)
//   coef_addr/data    : external combinational coefficient ROM port
//   ready / busy      : IDLE / not IDLE
//   done              : one-cycle completion pulse
//   result, ovf       : last completed sum and its sticky saturation flag
module series_eval
  import series_pkg::*;
#(
  parameter  int WIDTH  = WIDTH_DEF,
  parameter  int FRAC   = FRAC_DEF,
  parameter  int NTERMS = NTERMS_DEF,
  localparam int CW     = $clog2(NTERMS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic signed [WIDTH-1:0] x,
  input  logic        [CW-1:0]    nterms,
  output logic        [CW-1:0]    coef_addr,
  input  logic signed [WIDTH-1:0] coef_data,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] result,
  output logic                    ovf
);

  localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(1) << FRAC;
  localparam logic        [CW-1:0]    NMAX = CW'(NTERMS);
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic        [2:0]       state_q,  state_d;
  logic signed [WIDTH-1:0] x_q,      x_d;
  logic        [CW-1:0]    n_q,      n_d;
  logic signed [WIDTH-1:0] t_q,      t_d;      // current power x^i
  logic signed [WIDTH-1:0] a_q,      a_d;      // running sum
  logic signed [WIDTH-1:0] p_q,      p_d;      // current term c_i*x^i
  logic        [CW-1:0]    i_q,      i_d;
  logic                    iovf_q,   iovf_d;   // sticky flag of this run
  logic signed [WIDTH-1:0] result_q, result_d;
  logic                    ovf_q,    ovf_d;

  // Shared multiplier: t*c_i in MULC, t*x in MULX.
  logic signed [WIDTH-1:0] mul_b;
  logic signed [WIDTH-1:0] mul_y;
  logic                    mul_ovf;

  assign mul_b = (state_q == S_MULX) ? x_q : coef_data;

  sat_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (
    .a   (t_q),
    .b   (mul_b),
    .y   (mul_y),
    .ovf (mul_ovf)
  );

  // Saturating accumulator add: one guard bit is enough to see overflow.
  logic signed [WIDTH:0]   sum_w;
  logic signed [WIDTH-1:0] add_y;
  logic                    add_ovf;
  sat_e                    add_sat;
  logic        [CW-1:0]    i_inc;

  always_comb begin
    sum_w   = {a_q[WIDTH-1], a_q} + {p_q[WIDTH-1], p_q};
    add_sat = sat_check(64'(sum_w), WIDTH);
    add_ovf = (add_sat != SAT_NONE);
    case (add_sat)
      SAT_HI:  add_y = SMAX;
      SAT_LO:  add_y = SMIN;
      default: add_y = sum_w[WIDTH-1:0];
    endcase
    i_inc = i_q + CW'(1);
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    n_d      = n_q;
    t_d      = t_q;
    a_d      = a_q;
    p_d      = p_q;
    i_d      = i_q;
    iovf_d   = iovf_q;
    result_d = result_q;
    ovf_d    = ovf_q;

    // abort outranks every other transition and touches nothing else.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_INIT;
            x_d     = x;
            n_d     = (nterms > NMAX) ? NMAX : nterms;
          end
        end
        S_INIT: begin
          t_d    = ONE;
          a_d    = '0;
          i_d    = '0;
          iovf_d = 1'b0;
          if (n_q != '0) begin
            state_d = S_MULC;
          end else begin
            // Empty series: the freshly cleared sum and flag are the answer.
            state_d  = S_DONE;
            result_d = '0;
            ovf_d    = 1'b0;
          end
        end
        S_MULC: begin
          p_d     = mul_y;
          iovf_d  = iovf_q | mul_ovf;
          state_d = S_ACC;
        end
        S_ACC: begin
          a_d    = add_y;
          iovf_d = iovf_q | add_ovf;
          i_d    = i_inc;
          if (i_inc == n_q) begin
            // result/ovf load on the edge entering DONE, so they take the
            // post-add values rather than the registered ones.
            state_d  = S_DONE;
            result_d = add_y;
            ovf_d    = iovf_q | add_ovf;
          end else begin
            state_d = S_MULX;
          end
        end
        S_MULX: begin
          t_d     = mul_y;
          iovf_d  = iovf_q | mul_ovf;
          state_d = S_MULC;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  // NOTE: every register, data path included, is cleared by rst so outputs
  // are defined immediately after reset (there is no memory array here).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      n_q      <= '0;
      t_q      <= '0;
      a_q      <= '0;
      p_q      <= '0;
      i_q      <= '0;
      iovf_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      n_q      <= n_d;
      t_q      <= t_d;
      a_q      <= a_d;
      p_q      <= p_d;
      i_q      <= i_d;
      iovf_q   <= iovf_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign coef_addr = i_q;
  assign ready     = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_series_eval.sv
// tb_series_eval -- scoreboard bench for series_eval (WIDTH=16, FRAC=12).
// Stimulus pushes {result, ovf, done cycle} per accepted run; a monitor on
// the falling edge pops and compares whenever done is high.
module tb_series_eval;

  localparam int W  = 16;
  localparam int CW = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                abort;
  logic signed [W-1:0] x;
  logic [CW-1:0]       nterms;
  logic [CW-1:0]       coef_addr;
  logic signed [W-1:0] coef_data;
  logic                ready;
  logic                busy;
  logic                done;
  logic signed [W-1:0] result;
  logic                ovf;

  logic signed [W-1:0] rom [16];
  assign coef_data = rom[coef_addr];

  series_eval dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .x         (x),
    .nterms    (nterms),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Rising-edge count; read on falling edges only.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [W-1:0] res;
    logic                ovf;
    int                  at;
    string               name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", int'(done), 0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, int'(result), int'(e.res));
        check({e.name, "_ovf"},    int'(ovf),    int'(e.ovf));
        check({e.name, "_cycle"},  cyc,          e.at);
      end
    end
  end

  task automatic fill_rom(input logic signed [W-1:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  // Waits for ready on a falling edge, presents the request there, and
  // returns one falling edge later (INIT). lat = expected done cycle,
  // counting INIT as cycle 1.
  task automatic issue(input string name, input logic signed [W-1:0] xv,
                       input logic [CW-1:0] nv, input bit hold,
                       input bit expect_done, input logic signed [W-1:0] er,
                       input logic eo, input int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        check({name, "_ready_timeout"}, int'(ready), 1);
        return;
      end
    end while (ready !== 1'b1);
    x      = xv;
    nterms = nv;
    start  = 1'b1;
    if (expect_done) sb.push_back('{er, eo, cyc + lat, name});
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0) || (ready !== 1'b1)) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        check("drain_timeout", sb.size(), 0);
        sb.delete();
        return;
      end
    end
  endtask

  task automatic check_idle_zero(input string name);
    check({name, "_ready"},  int'(ready),  1);
    check({name, "_busy"},   int'(busy),   0);
    check({name, "_done"},   int'(done),   0);
    check({name, "_result"}, int'(result), 0);
    check({name, "_ovf"},    int'(ovf),    0);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    x      = '0;
    nterms = '0;
    fill_rom('0);
    #12;
    check_idle_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1 + 0.5 + 0.25 + 0.125 = 1.875
    fill_rom(16'sd4096);
    issue("half_x4", 16'sd2048, 4'd4, 1'b0, 1'b1, 16'sd7680, 1'b0, 13);
    wait_idle();

    rom[0] = -16'sd1234;
    issue("one_term", 16'sd1000, 4'd1, 1'b0, 1'b1, -16'sd1234, 1'b0, 4);
    wait_idle();

    issue("zero_terms", 16'sd1000, 4'd0, 1'b0, 1'b1, 16'sd0, 1'b0, 2);
    wait_idle();

    // 4 + 16 + 64 with 4.0 coefficients: saturates positive.
    fill_rom(16'sd16384);
    issue("sat_pos", 16'sd16384, 4'd3, 1'b0, 1'b1, 16'sd32767, 1'b1, 10);
    wait_idle();

    issue("x_zero", 16'sd0, 4'd2, 1'b0, 1'b1, 16'sd16384, 1'b0, 7);
    wait_idle();

    // 1 - 0.5 + 0.25 = 0.75
    fill_rom(16'sd4096);
    issue("neg_x", -16'sd2048, 4'd3, 1'b0, 1'b1, 16'sd3072, 1'b0, 10);
    wait_idle();

    // x = -1 LSB: t*x truncates to -1 LSB, so sum is 4096 - 1.
    issue("trunc", -16'sd1, 4'd2, 1'b0, 1'b1, 16'sd4095, 1'b0, 7);
    wait_idle();

    // -8 + -8 saturates negative.
    fill_rom(-16'sd32768);
    issue("sat_neg", 16'sd4096, 4'd2, 1'b0, 1'b1, -16'sd32768, 1'b1, 7);
    wait_idle();

    // nterms=15 clamps to 8: only rom[0..7] (100 each) contribute.
    for (int i = 0; i < 16; i++) rom[i] = (i < 8) ? 16'sd100 : 16'sd5000;
    issue("clamp", 16'sd4096, 4'd15, 1'b0, 1'b1, 16'sd800, 1'b0, 25);
    wait_idle();

    // Abort in cycle 5 (MULC of term 1); issue returns in cycle 1.
    fill_rom(16'sd4096);
    issue("abort_run", 16'sd2048, 4'd4, 1'b0, 1'b0, 16'sd0, 1'b0, 0);
    repeat (4) @(negedge clk);
    check("abort_busy_before", int'(busy), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ready",  int'(ready),  1);
    check("abort_busy",   int'(busy),   0);
    check("abort_result", int'(result), 800);
    check("abort_ovf",    int'(ovf),    0);
    repeat (3) @(negedge clk);

    // Reset during MULX (cycle 4).
    issue("rst_run", 16'sd2048, 4'd4, 1'b0, 1'b0, 16'sd0, 1'b0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back with start held: each done one IDLE cycle apart.
    issue("b2b_0", 16'sd2048, 4'd4, 1'b1, 1'b1, 16'sd7680, 1'b0, 13);
    issue("b2b_1", 16'sd0, 4'd1, 1'b1, 1'b1, 16'sd4096, 1'b0, 4);
    issue("b2b_2", -16'sd2048, 4'd3, 1'b0, 1'b1, 16'sd3072, 1'b0, 10);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
